arcade_input_mapper: RTL and testbench
======================================

# arcade_input_mapper

Parametrised control-input front end for arcade cores. It decodes `ps2_key` events through a run-time-loadable keymap table into per-player button vectors and merges them with the HPS joystick words. Coin buttons get a minimum-width pulse stretcher, and selected buttons get a per-button autofire generator. It sits between `hps_io` and the game core, replacing hard-wired keyboard case statements.

## Interface

**Parameters**
- `NUM_BTN`, 16 — buttons per player; equals the joystick word width.
- `NUM_PLAYERS`, 2 — player channels, 1..4.
- `MAP_DEPTH`, 16 — keymap entries, power of two, 4..64.
- `COIN_IDX`, 7 — button index treated as coin.
- `COIN_PULSE`, 262144 — minimum coin assertion, in clk_sys cycles.
- `AUTOFIRE_DIV`, 1048576 — autofire half-period, in cycles.

**Ports**
- `clk_sys`, in, 1 — system clock.
- `reset_n`, in, 1 — asynchronous, active-low reset.
- `ps2_key`, in, 65 — hps_io key word.
  - [64] toggles once per event.
  - [7:0] scancode.
  - [15:8] is F0 on release.
  - [23:16] is E0 on extended release.
  - [63:24] nonzero for PRNSCR/PAUSE.
- `joy_in`, in, NUM_PLAYERS*NUM_BTN — joystick words; player p at [p*NUM_BTN +: NUM_BTN].
- `map_we`, in, 1 — keymap write strobe.
- `map_addr`, in, clog2(MAP_DEPTH) — entry index.
- `map_data`, in, 1+clog2(NUM_PLAYERS)+9+clog2(NUM_BTN) — entry {valid, player, code[8:0]={ext,scancode}, btn}.
- `af_mask`, in, NUM_BTN — buttons with autofire enabled, shared by all players.
- `btn_out`, out, NUM_PLAYERS*NUM_BTN — final buttons, active-high, same packing as `joy_in`.
- `busy`, out, 1 — scan in progress.
- `overflow`, out, 1 — sticky flag; a key event was dropped.

## Operation

**Event capture**
- Register `ps2_key[64]`; any change is an event.
- Decode:
  - `pressed = ps2_key[15:8] != F0`
  - `ext = pressed ? ps2_key[15:8]==E0 : ps2_key[23:16]==E0`
  - `code = {ext, ps2_key[7:0]}`
- If `ps2_key[63:24] != 0`, the event is discarded (no scan, no overflow).
- The decoded {code, pressed} is stored in a 1-deep pending register.
- If an event arrives while the pending register is full, the new event is dropped and `overflow` is set. `overflow` clears only on reset.

**FSM**
- IDLE: if pending is valid, load it into the active slot, clear pending, set idx=0, go to SCAN.
- SCAN: one entry per cycle. For an entry with valid=1 and code match, set or clear `kbd[player][btn]` according to `pressed`. All matching entries apply, so one key can drive several buttons or players. At idx=MAP_DEPTH-1, go to IDLE.
- `busy` = (state==SCAN).

**Keymap**
- Held in registers, cleared (all invalid) on reset.
- A `map_we` write takes effect the next cycle, in any state.
- An entry read by SCAN in the same cycle as its write uses the old contents.
- Entries with player >= NUM_PLAYERS are ignored.

**Merge**
- `raw[p] = kbd[p] | joy_in[p]`.

**Autofire**
- One free-running counter wraps at AUTOFIRE_DIV-1 and toggles the phase `af_ph`.
- On a raw rising edge of any af_mask button, the counter and phase reset so that `af_ph` = 1.
- For masked buttons, `out = raw & af_ph`. Unmasked buttons pass through `raw`.

**Coin stretch**
- Each player has a counter.
- A rising edge of `raw[p][COIN_IDX]` loads COIN_PULSE-1.
- The counter decrements to 0 and saturates there.
- `out[p][COIN_IDX] = raw | (cnt != 0)`.
- A new edge during countdown reloads the counter.
- COIN_IDX is not subject to autofire.

## Timing

- **Reset:**
  - `btn_out` = 0, `busy` = 0, `overflow` = 0.
  - FSM in IDLE, pending empty, kbd = 0, keymap invalid.
  - Counters = 0, `af_ph` = 1.
- **Event latency:** toggle seen at edge T; pending set at T+1; SCAN starts at T+2; state for entry i updates at T+3+i.
- **Worst-case keyboard-to-`btn_out` latency:** MAP_DEPTH+3 cycles. `btn_out` is registered one stage after `kbd`/`raw`.
- **Joystick path:** `joy_in` reaches `btn_out` in 1 cycle (registered), except for autofire/coin effects.
- **Event acceptance:** back-to-back events are accepted every MAP_DEPTH+1 cycles without loss. A second event within one scan is buffered. A third is dropped.
- **Reset mid-scan:** the scan aborts and all state returns to reset values.

## Test plan

1. Reset, then write entry 0 = {1, p0, 0x075, btn3}. Send a press of 0x75 (toggle [64]). `btn_out[3]` rises at T+4+0, `busy` is high for MAP_DEPTH cycles. Release (F0) clears `btn_out[3]`.
2. Map two entries for code 0x029 (p0 btn4, p1 btn4). A press sets bits 4 and NUM_BTN+4 in the same scan. Extended 0x114 (E0 14) does not match an entry for 0x014.
3. Send three events in consecutive cycles during one scan. The first two apply in order, the third is dropped, and `overflow` = 1 and stays 1.
4. Assert `joy_in[7]` for 1 cycle with COIN_PULSE=8. `btn_out[7]` is high for exactly 8 cycles. A re-pulse at cycle 5 extends it to cycle 13.
5. With AUTOFIRE_DIV=4 and af_mask[4]=1, hold `joy_in[4]`. `btn_out[4]` is 1 for 4 cycles, 0 for 4 cycles, repeating. Release forces 0 immediately.
6. With a PAUSE event ([63:24]≠0), nothing changes and `busy` stays 0. Drive `reset_n` low mid-scan: all outputs read 0 on the next sample.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// Keymap-driven keyboard decoder merged with joystick words, with a per-player
// coin pulse stretcher and a shared autofire phase applied on the registered output.
module arcade_input_mapper #(
  parameter int unsigned NUM_BTN      = 16,
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned MAP_DEPTH    = 16,
  parameter int unsigned COIN_IDX     = 7,
  parameter int unsigned COIN_PULSE   = 262144,
  parameter int unsigned AUTOFIRE_DIV = 1048576
) (
  input  logic                                           clk_sys,
  input  logic                                           reset_n,
  input  logic [64:0]                                    ps2_key,
  input  logic [NUM_PLAYERS*NUM_BTN-1:0]                 joy_in,
  input  logic                                           map_we,
  input  logic [$clog2(MAP_DEPTH)-1:0]                   map_addr,
  input  logic [$clog2(NUM_PLAYERS)+$clog2(NUM_BTN)+9:0] map_data,
  input  logic [NUM_BTN-1:0]                             af_mask,
  output logic [NUM_PLAYERS*NUM_BTN-1:0]                 btn_out,
  output logic                                           busy,
  output logic                                           overflow
);

  localparam int unsigned AW  = $clog2(MAP_DEPTH);
  localparam int unsigned PLW = $clog2(NUM_PLAYERS);
  localparam int unsigned BW  = $clog2(NUM_BTN);
  localparam int unsigned EW  = PLW + BW + 10;
  localparam int unsigned NB  = NUM_PLAYERS * NUM_BTN;
  localparam int unsigned KW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CW  = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
  localparam int unsigned AFW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StScan = 1'b1;

  logic          tog_q, tog_prev_q;
  logic [23:0]   key_q;
  logic          pause_q;
  logic          pend_valid_q, pend_valid_d;
  logic [8:0]    pend_code_q, pend_code_d;
  logic          pend_pressed_q, pend_pressed_d;
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [8:0]    act_code_q, act_code_d;
  logic          act_pressed_q, act_pressed_d;
  logic [NB-1:0] kbd_q, kbd_d;
  logic [EW-1:0] map_q [MAP_DEPTH];
  logic          overflow_q, overflow_d;
  logic [NB-1:0] raw_q, btn_q;
  logic [AFW-1:0] af_cnt_q, af_cnt_d, af_base_cnt;
  logic          af_ph_q, af_ph_d, af_base_ph;
  logic [CW-1:0] coin_cnt_q [NUM_PLAYERS];
  logic [CW-1:0] coin_cnt_d [NUM_PLAYERS];

  logic          evt_valid, evt_pressed, evt_ext, consume, pend_keep;
  logic [EW-1:0] ent;
  logic [2:0]    ent_player;
  logic [BW-1:0] ent_btn;
  logic [8:0]    ent_code;
  logic          ent_valid, hit;
  logic [KW-1:0] kbd_bit;

  logic [NUM_PLAYERS-1:0][NUM_BTN-1:0] raw, rise, btn_d;
  logic [NUM_BTN-1:0] coin_mask, af_en;
  logic               af_rise;

  // Event decode from the registered key word
  assign evt_valid   = (tog_q != tog_prev_q) && !pause_q;
  assign evt_pressed = key_q[15:8] != 8'hF0;
  assign evt_ext     = evt_pressed ? (key_q[15:8] == 8'hE0) : (key_q[23:16] == 8'hE0);
  assign consume     = (state_q == StIdle) && pend_valid_q;
  assign pend_keep   = pend_valid_q && !consume;

  assign ent       = map_q[idx_q];
  assign ent_btn   = ent[BW-1:0];
  assign ent_code  = ent[BW +: 9];
  assign ent_valid = ent[EW-1];

  if (PLW > 0) begin : g_player
    assign ent_player = 3'(ent[BW+9 +: PLW]);
  end else begin : g_no_player
    assign ent_player = 3'd0;
  end

  assign hit = (state_q == StScan) && ent_valid && (ent_code == act_code_q) &&
               (32'(ent_player) < NUM_PLAYERS) && (32'(ent_btn) < NUM_BTN);
  assign kbd_bit = KW'(32'(ent_player) * NUM_BTN + 32'(ent_btn));

  always_comb begin
    pend_valid_d   = pend_keep;
    pend_code_d    = pend_code_q;
    pend_pressed_d = pend_pressed_q;
    overflow_d     = overflow_q;
    if (evt_valid) begin
      if (pend_keep) begin
        overflow_d = 1'b1;
      end else begin
        pend_valid_d   = 1'b1;
        pend_code_d    = {evt_ext, key_q[7:0]};
        pend_pressed_d = evt_pressed;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    act_code_d    = act_code_q;
    act_pressed_d = act_pressed_q;
    kbd_d         = kbd_q;
    if (state_q == StIdle) begin
      if (pend_valid_q) begin
        act_code_d    = pend_code_q;
        act_pressed_d = pend_pressed_q;
        idx_d         = '0;
        state_d       = StScan;
      end
    end else begin
      if (hit) kbd_d[kbd_bit] = act_pressed_q;
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(MAP_DEPTH - 1)) state_d = StIdle;
    end
  end

  // Output stage: autofire phase restarts high on any masked rising edge
  always_comb begin
    coin_mask           = '0;
    coin_mask[COIN_IDX] = 1'b1;
    af_en               = af_mask & ~coin_mask;
    raw                 = kbd_q | joy_in;
    rise                = raw & ~raw_q;
    af_rise             = 1'b0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      af_rise = af_rise | (|(rise[p] & af_en));
    end
    af_base_cnt = af_rise ? '0 : af_cnt_q;
    af_base_ph  = af_rise | af_ph_q;
    if (af_base_cnt == AFW'(AUTOFIRE_DIV - 1)) begin
      af_cnt_d = '0;
      af_ph_d  = ~af_base_ph;
    end else begin
      af_cnt_d = af_base_cnt + AFW'(1);
      af_ph_d  = af_base_ph;
    end
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      btn_d[p] = (raw[p] & ~af_en) | (raw[p] & af_en & {NUM_BTN{af_base_ph}});
      btn_d[p][COIN_IDX] = raw[p][COIN_IDX] | (coin_cnt_q[p] != '0);
      if (rise[p][COIN_IDX]) begin
        coin_cnt_d[p] = CW'(COIN_PULSE - 1);
      end else if (coin_cnt_q[p] != '0) begin
        coin_cnt_d[p] = coin_cnt_q[p] - CW'(1);
      end else begin
        coin_cnt_d[p] = '0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q          <= 1'b0;
      tog_prev_q     <= 1'b0;
      key_q          <= '0;
      pause_q        <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_code_q    <= '0;
      pend_pressed_q <= 1'b0;
      state_q        <= StIdle;
      idx_q          <= '0;
      act_code_q     <= '0;
      act_pressed_q  <= 1'b0;
      kbd_q          <= '0;
      overflow_q     <= 1'b0;
      raw_q          <= '0;
      btn_q          <= '0;
      af_cnt_q       <= '0;
      af_ph_q        <= 1'b1;
      for (int i = 0; i < int'(MAP_DEPTH); i++) map_q[i] <= '0;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) coin_cnt_q[p] <= '0;
    end else begin
      tog_q          <= ps2_key[64];
      tog_prev_q     <= tog_q;
      key_q          <= ps2_key[23:0];
      pause_q        <= ps2_key[63:24] != '0;
      pend_valid_q   <= pend_valid_d;
      pend_code_q    <= pend_code_d;
      pend_pressed_q <= pend_pressed_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      act_code_q     <= act_code_d;
      act_pressed_q  <= act_pressed_d;
      kbd_q          <= kbd_d;
      overflow_q     <= overflow_d;
      raw_q          <= raw;
      btn_q          <= btn_d;
      af_cnt_q       <= af_cnt_d;
      af_ph_q        <= af_ph_d;
      if (map_we) map_q[map_addr] <= map_data;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) coin_cnt_q[p] <= coin_cnt_d[p];
    end
  end

  assign btn_out  = btn_q;
  assign busy     = (state_q == StScan);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench: a timing-level reference model pushes the expected outputs for
// every clock edge; a negedge monitor pops and compares against the DUT.
`timescale 1ns/1ps
module tb_arcade_input_mapper;
  localparam int NBTN = 16;
  localparam int NP   = 2;
  localparam int MD   = 8;
  localparam int CI   = 7;
  localparam int CP   = 8;
  localparam int AFD  = 4;
  localparam int NBT  = NP * NBTN;

  logic            clk_sys = 1'b0;
  logic            reset_n;
  logic [64:0]     ps2_key;
  logic [NBT-1:0]  joy_in;
  logic            map_we;
  logic [2:0]      map_addr;
  logic [14:0]     map_data;
  logic [NBTN-1:0] af_mask;
  logic [NBT-1:0]  btn_out;
  logic            busy;
  logic            overflow;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .NUM_BTN(NBTN), .NUM_PLAYERS(NP), .MAP_DEPTH(MD), .COIN_IDX(CI),
    .COIN_PULSE(CP), .AUTOFIRE_DIV(AFD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_in),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data), .af_mask(af_mask),
    .btn_out(btn_out), .busy(busy), .overflow(overflow)
  );

  typedef struct packed { logic [NBT-1:0] btn; logic bsy; logic ovf; } exp_t;
  typedef struct { int s; logic [8:0] code; logic pressed; } ev_t;

  exp_t exp_q[$];
  ev_t  ev_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state
  logic [NBT-1:0] m_kbd, m_raw_prev;
  logic           m_valid [MD];
  int             m_player[MD];
  int             m_code  [MD];
  int             m_btn   [MD];
  logic           m_ovf, m_ovf_next, m_tog, m_af_started;
  int             m_s_last, m_t0;
  int             m_coin_last[NP];

  always @(posedge clk_sys) begin : model
    exp_t e;
    logic [NBT-1:0] raw, outv;
    logic af_rise, ph, pr, ext, bsy;
    int i, s, ix;
    cyc++;
    e = '0;
    if (!reset_n) begin
      m_kbd = '0; m_raw_prev = '0; m_ovf = 0; m_ovf_next = 0; m_tog = 0;
      m_af_started = 0; m_s_last = -1000; m_t0 = 0;
      for (int k = 0; k < MD; k++) m_valid[k] = 0;
      for (int p = 0; p < NP; p++) m_coin_last[p] = -1000000;
      ev_q.delete();
    end else begin
      if (!m_af_started) begin m_t0 = cyc; m_af_started = 1; end
      if (m_ovf_next) m_ovf = 1;
      m_ovf_next = 0;
      raw = m_kbd | joy_in;
      af_rise = 0;
      for (int p = 0; p < NP; p++)
        for (int b = 0; b < NBTN; b++)
          if (b != CI && af_mask[b] && raw[p*NBTN+b] && !m_raw_prev[p*NBTN+b]) af_rise = 1;
      if (af_rise) m_t0 = cyc;
      ph = (((cyc - m_t0) / AFD) % 2) == 0;
      for (int p = 0; p < NP; p++)
        if (raw[p*NBTN+CI] && !m_raw_prev[p*NBTN+CI]) m_coin_last[p] = cyc;
      for (int p = 0; p < NP; p++)
        for (int b = 0; b < NBTN; b++) begin
          ix = p*NBTN + b;
          if (b == CI) outv[ix] = raw[ix] || ((cyc - m_coin_last[p]) < CP);
          else if (af_mask[b]) outv[ix] = raw[ix] && ph;
          else outv[ix] = raw[ix];
        end
      m_raw_prev = raw;
      // Entry i of a scan starting at edge s is applied at edge s+1+i, old map contents
      foreach (ev_q[j])
        if (cyc >= ev_q[j].s + 1 && cyc <= ev_q[j].s + MD) begin
          i = cyc - ev_q[j].s - 1;
          if (m_valid[i] && m_code[i] == int'(ev_q[j].code) && m_player[i] < NP &&
              m_btn[i] < NBTN)
            m_kbd[m_player[i]*NBTN + m_btn[i]] = ev_q[j].pressed;
        end
      if (map_we) begin
        m_valid[map_addr]  = map_data[14];
        m_player[map_addr] = int'(map_data[13]);
        m_code[map_addr]   = int'(map_data[12:4]);
        m_btn[map_addr]    = int'(map_data[3:0]);
      end
      if (ps2_key[64] != m_tog) begin
        m_tog = ps2_key[64];
        if (ps2_key[63:24] == '0) begin
          pr  = ps2_key[15:8] != 8'hF0;
          ext = pr ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
          if (m_s_last > cyc + 1) begin
            m_ovf_next = 1;
          end else begin
            s = (cyc + 2 > m_s_last + MD + 1) ? cyc + 2 : m_s_last + MD + 1;
            ev_q.push_back('{s, {ext, ps2_key[7:0]}, pr});
            m_s_last = s;
          end
        end
      end
      bsy = 0;
      foreach (ev_q[j]) if (cyc >= ev_q[j].s && cyc <= ev_q[j].s + MD - 1) bsy = 1;
      while (ev_q.size() > 0 && ev_q[0].s + MD < cyc) void'(ev_q.pop_front());
      e.btn = outv; e.bsy = bsy; e.ovf = m_ovf;
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk_sys) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("btn_out", btn_out, e.btn);
      chk("busy", 32'(busy), 32'(e.bsy));
      chk("overflow", 32'(overflow), 32'(e.ovf));
    end
  end

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic map_wr(input int addr, input logic v, input int pl, input logic [8:0] code,
                        input int btn);
    step();
    map_we   = 1'b1;
    map_addr = 3'(addr);
    map_data = {v, 1'(pl), code, 4'(btn)};
    step();
    map_we   = 1'b0;
  endtask

  task automatic key(input logic [8:0] code, input logic pressed, input logic pause);
    logic [64:0] k;
    k       = '0;
    k[64]   = ~ps2_key[64];
    k[7:0]  = code[7:0];
    if (pressed) begin
      k[15:8] = code[8] ? 8'hE0 : 8'h00;
    end else begin
      k[15:8]  = 8'hF0;
      k[23:16] = code[8] ? 8'hE0 : 8'h00;
    end
    if (pause) k[63:24] = 40'h00_0000_0E11;
    step();
    ps2_key = k;
  endtask

  logic [8:0] codes[5];

  initial begin
    codes = '{9'h075, 9'h029, 9'h014, 9'h114, 9'h06B};
    reset_n = 1'b0; ps2_key = '0; joy_in = '0; map_we = 1'b0;
    map_addr = '0; map_data = '0; af_mask = '0;
    idle(3);
    reset_n = 1'b1;
    // Single mapped key press/release
    map_wr(0, 1, 0, 9'h075, 3);
    key(9'h075, 1, 0); idle(MD + 4);
    key(9'h075, 0, 0); idle(MD + 4);
    // One key driving two players; extended code must not alias
    map_wr(1, 1, 0, 9'h029, 4);
    map_wr(2, 1, 1, 9'h029, 4);
    map_wr(3, 1, 0, 9'h014, 5);
    key(9'h029, 1, 0); idle(MD + 4);
    key(9'h114, 1, 0); idle(MD + 4);
    key(9'h014, 1, 0); idle(MD + 4);
    // Three back-to-back events: third is dropped, overflow sticks
    key(9'h075, 1, 0); key(9'h029, 0, 0); key(9'h075, 0, 0); idle(3 * MD);
    // Coin stretch with re-pulse during countdown
    step(); joy_in[CI] = 1'b1; step(); joy_in[CI] = 1'b0;
    idle(4); joy_in[CI] = 1'b1; step(); joy_in[CI] = 1'b0; idle(16);
    // Autofire on button 4 of player 1
    step(); af_mask[4] = 1'b1; joy_in[NBTN+4] = 1'b1; idle(20);
    joy_in[NBTN+4] = 1'b0; idle(4); af_mask = '0;
    // Pause event ignored, then reset in the middle of a scan
    key(9'h075, 1, 1); idle(6);
    key(9'h075, 1, 0); idle(5);
    reset_n = 1'b0; step(); step(); reset_n = 1'b1; idle(MD + 4);
    // Randomised traffic
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) begin
        map_wr($urandom_range(0, MD - 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
               codes[$urandom_range(0, 4)], $urandom_range(0, NBTN - 1));
      end else if (r < 45) begin
        key(codes[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0);
      end else if (r < 70) begin
        step(); joy_in = $urandom & $urandom & $urandom;
      end else if (r < 75) begin
        step(); af_mask = 16'($urandom & $urandom);
      end else if (r < 76) begin
        step(); reset_n = 1'b0; step(); reset_n = 1'b1;
      end else begin
        idle($urandom_range(1, MD + 2));
      end
    end
    joy_in = '0;
    idle(MD + 6);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
